// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the serial test-pattern transmitter.
//   state_t  : FSM state encoding (IDLE/SHIFT/GAP)
//   DEF_PAT  : default 3-bit pattern sent when pat_sel=0
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [2:0] DEF_PAT = 3'b101;

endpackage

// File: rtl/pattern_tx101_if.sv
// Control/stream bundle of the pattern transmitter.
//   start, abort, pat_sel, pat_in, rep : requests into the transmitter
//   data, data_valid, busy, done        : serial stream and status out
//   master : the block that drives requests and observes the stream
//   slave  : the transmitter itself
interface pattern_tx101_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             pat_sel;
    logic [PAT_W-1:0] pat_in;
    logic [CNT_W-1:0] rep;
    logic             data;
    logic             data_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pat_sel, pat_in, rep,
        input  data, data_valid, busy, done
    );

    modport slave (
        input  start, abort, pat_sel, pat_in, rep,
        output data, data_valid, busy, done
    );
endinterface

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register, MSB first, zero fill.
//   clk, rst : clock, asynchronous active-high clear
//   clr      : synchronous clear (highest priority)
//   load     : capture din
//   shift    : shift left one position, LSB filled with 0
//   din      : parallel data
//   msb      : current MSB (registered)
module piso_shift #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);
    logic [W-1:0] sr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign msb = sr[W-1];
endmodule

// File: rtl/pattern_tx101.sv
// Serial test-pattern transmitter. Shifts a PAT_W-bit pattern out MSB first,
// rep times, with GAP idle cycles between repetitions.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pattern_tx101_if.slave (start/abort/pat_sel/pat_in/rep in,
//              data/data_valid/busy/done out; all outputs registered)
module pattern_tx101
    import pattern_tx_pkg::*;
#(
    parameter int               PAT_W = 3,
    parameter logic [PAT_W-1:0] PAT   = DEF_PAT,
    parameter int               CNT_W = 8,
    parameter int               GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    pattern_tx101_if.slave   bus
);
    localparam int BW = $clog2(PAT_W);
    localparam int GW = (GAP > 0 && $clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;

    state_t           state;
    logic [BW-1:0]    bit_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [PAT_W-1:0] pat_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [PAT_W-1:0] pat_start;
    logic [PAT_W-1:0] sr_din;
    logic             sr_load;
    logic             sr_shift;
    logic             sr_clr;
    logic             last_bit;
    logic             last_rep;

    assign pat_start = bus.pat_sel ? bus.pat_in : PAT;
    assign last_bit  = (bit_cnt == '0);
    assign last_rep  = (rep_cnt == CNT_W'(1));

    // Shift-register control. The final shift of a repetition empties the
    // register, so data reads 0 during GAP and IDLE without an extra clear.
    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_clr   = 1'b0;
        sr_din   = pat_q;
        if (bus.abort) begin
            sr_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start && bus.rep != '0) begin
                        sr_load = 1'b1;
                        sr_din  = pat_start;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit && !last_rep && GAP == 0) sr_load  = 1'b1;
                    else                                   sr_shift = 1'b1;
                end
                ST_GAP: begin
                    if (gap_cnt == '0) sr_load = 1'b1;
                end
                default: sr_clr = 1'b1;
            endcase
        end
    end

    // NOTE: only control registers are reset; the pattern holding register
    // is reset too here, but a wide datapath register would not need to be.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            pat_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                rep_cnt <= '0;
                gap_cnt <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            if (bus.rep != '0) begin
                                state   <= ST_SHIFT;
                                pat_q   <= pat_start;
                                rep_cnt <= bus.rep;
                                bit_cnt <= BW'(PAT_W - 1);
                                valid_q <= 1'b1;
                                busy_q  <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    ST_SHIFT: begin
                        if (!last_bit) begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (last_rep) begin
                            state   <= ST_IDLE;
                            rep_cnt <= '0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt - 1'b1;
                            if (GAP == 0) begin
                                bit_cnt <= BW'(PAT_W - 1);
                            end else begin
                                state   <= ST_GAP;
                                gap_cnt <= GW'(GAP - 1);
                                valid_q <= 1'b0;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == '0) begin
                            state   <= ST_SHIFT;
                            bit_cnt <= BW'(PAT_W - 1);
                            valid_q <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    piso_shift #(.W(PAT_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .clr   (sr_clr),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sr_din),
        .msb   (bus.data)
    );

    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_pattern_tx101.sv
// Directed bench for pattern_tx101. Two instances: GAP=0 and GAP=2.
// Expected outputs are packed as {data, data_valid, busy, done}.
module tb_pattern_tx101;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pattern_tx101_if #(.PAT_W(3), .CNT_W(8)) if0 ();
    pattern_tx101_if #(.PAT_W(3), .CNT_W(8)) if2 ();

    pattern_tx101 #(.PAT_W(3), .PAT(3'b101), .CNT_W(8), .GAP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    pattern_tx101 #(.PAT_W(3), .PAT(3'b101), .CNT_W(8), .GAP(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    function automatic logic [3:0] obs0();
        return {if0.data, if0.data_valid, if0.busy, if0.done};
    endfunction

    function automatic logic [3:0] obs2();
        return {if2.data, if2.data_valid, if2.busy, if2.done};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {data,valid,busy,done}=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] bits9;
        logic [7:0] gap_seq [0:8];

        if0.start = 0; if0.abort = 0; if0.pat_sel = 0; if0.pat_in = '0; if0.rep = '0;
        if2.start = 0; if2.abort = 0; if2.pat_sel = 0; if2.pat_in = '0; if2.rep = '0;

        // Reset state
        #12;
        check("reset_dut0", obs0(), 4'b0000);
        check("reset_dut2", obs2(), 4'b0000);
        @(negedge clk);
        rst = 0;

        // 1: default pattern, rep=1
        tick();
        if0.rep = 8'd1; if0.start = 1;
        tick();
        if0.start = 0;
        check("t1_bit0", obs0(), 4'b1110);
        tick(); check("t1_bit1", obs0(), 4'b0110);
        tick(); check("t1_bit2", obs0(), 4'b1110);
        tick(); check("t1_done", obs0(), 4'b0001);
        tick(); check("t1_idle", obs0(), 4'b0000);

        // 2: rep=3, GAP=0 -> 101101101 back to back
        if0.rep = 8'd3; if0.start = 1;
        tick();
        if0.start = 0;
        bits9 = 9'b101101101;
        for (int i = 8; i >= 0; i--) begin
            check($sformatf("t2_bit%0d", 8 - i), obs0(), {bits9[i], 3'b110});
            tick();
        end
        check("t2_done", obs0(), 4'b0001);
        tick(); check("t2_idle", obs0(), 4'b0000);

        // 3: GAP=2 instance, user pattern 011, rep=2
        if2.pat_sel = 1; if2.pat_in = 3'b011; if2.rep = 8'd2; if2.start = 1;
        tick();
        if2.start = 0; if2.pat_in = 3'b111;
        gap_seq[0] = 8'b0110; gap_seq[1] = 8'b1110; gap_seq[2] = 8'b1110;
        gap_seq[3] = 8'b0010; gap_seq[4] = 8'b0010;
        gap_seq[5] = 8'b0110; gap_seq[6] = 8'b1110; gap_seq[7] = 8'b1110;
        gap_seq[8] = 8'b0001;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t3_cyc%0d", i + 1), obs2(), gap_seq[i][3:0]);
            tick();
        end
        check("t3_idle", obs2(), 4'b0000);

        // 4: rep=0 -> immediate done, no bits
        if0.rep = 8'd0; if0.start = 1;
        tick();
        if0.start = 0;
        check("t4_done", obs0(), 4'b0001);
        tick(); check("t4_idle1", obs0(), 4'b0000);
        tick(); check("t4_idle2", obs0(), 4'b0000);

        // 5: start held during transfer ignored, abort cancels, no done
        if0.pat_sel = 0; if0.rep = 8'd3; if0.start = 1;
        tick();
        if0.pat_sel = 1; if0.pat_in = 3'b000;
        check("t5_cyc1", obs0(), 4'b1110);
        tick();
        check("t5_cyc2_latched", obs0(), 4'b0110);
        if0.abort = 1;
        tick();
        check("t5_abort", obs0(), 4'b0000);
        if0.abort = 0; if0.start = 0;
        tick(); check("t5_no_done", obs0(), 4'b0000);
        // abort has priority over start in IDLE
        if0.start = 1; if0.abort = 1;
        tick();
        check("t5_abort_prio", obs0(), 4'b0000);
        if0.start = 0; if0.abort = 0;
        tick(); check("t5_abort_prio2", obs0(), 4'b0000);

        // 6: async reset mid-SHIFT, then full pattern, then back-to-back start
        if0.pat_sel = 0; if0.rep = 8'd1; if0.start = 1;
        tick();
        if0.start = 0;
        check("t6_bit0", obs0(), 4'b1110);
        tick(); check("t6_bit1", obs0(), 4'b0110);
        #2 rst = 1;
        #1 check("t6_async_rst", obs0(), 4'b0000);
        #2 rst = 0;
        if0.start = 1;
        tick();
        if0.start = 0;
        check("t6_re_bit0", obs0(), 4'b1110);
        tick(); check("t6_re_bit1", obs0(), 4'b0110);
        tick(); check("t6_re_bit2", obs0(), 4'b1110);
        tick(); check("t6_re_done", obs0(), 4'b0001);
        // start during the done cycle is accepted
        if0.start = 1;
        tick();
        if0.start = 0;
        check("t6_b2b_bit0", obs0(), 4'b1110);
        tick(); check("t6_b2b_bit1", obs0(), 4'b0110);
        tick(); check("t6_b2b_bit2", obs0(), 4'b1110);
        tick(); check("t6_b2b_done", obs0(), 4'b0001);
        tick(); check("t6_b2b_idle", obs0(), 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
